// File: rtl/rpn_pkg.sv
// rpn_executor shared types: opcodes, FSM states, widths.
// STACK_FULL is shared with the entry block.
package rpn_pkg;

  localparam int W     = 8;
  localparam int RES_W = 2 * W;

  localparam logic [1:0] STACK_FULL = 2'd3;

  localparam logic [W-1:0] OP_ADD = 8'h00;
  localparam logic [W-1:0] OP_SUB = 8'h01;
  localparam logic [W-1:0] OP_MUL = 8'h02;
  localparam logic [W-1:0] OP_DIV = 8'h03;
  localparam logic [W-1:0] OP_AND = 8'h04;
  localparam logic [W-1:0] OP_OR  = 8'h05;
  localparam logic [W-1:0] OP_XOR = 8'h06;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

endpackage

// File: rtl/rpn_executor_if.sv
// Stack-read / result bundle between entry block, executor and display.
// master = stack/display side, slave = executor.
interface rpn_executor_if;
  import rpn_pkg::*;

  logic [W-1:0]     T0;
  logic [W-1:0]     T1;
  logic [W-1:0]     T2;
  logic [1:0]       Contador;
  logic             start;
  logic             busy;
  logic             done;
  logic             erro;
  logic [RES_W-1:0] Resultado;
  logic [W-1:0]     Resto;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output T0, T1, T2, Contador, start,
    input  busy, done, erro, Resultado, Resto,
    input  flag_z, flag_c, flag_v
  );

  modport slave (
    input  T0, T1, T2, Contador, start,
    output busy, done, erro, Resultado, Resto,
    output flag_z, flag_c, flag_v
  );

endinterface

// File: rtl/rpn_seq_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one step per clock.
// fin marks the cycle whose next-step value is the final result.
module rpn_seq_muldiv
  import rpn_pkg::*;
#(
  parameter int ITER = W
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             go,
  input  logic             is_div,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             fin,
  output logic [RES_W-1:0] prod_quot,
  output logic [W-1:0]     rem
);

  localparam int CW = $clog2(ITER) + 1;

  logic             run;
  logic             div_q;
  logic [CW-1:0]    cnt;
  logic [W-1:0]     m;
  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] acc_n;
  logic [W:0]       sum;
  logic [W:0]       sh;
  logic [W+1:0]     df;

  // acc = {hi, lo}: mul {partial, multiplier}, div {remainder, quotient}
  always_comb begin
    sum = {1'b0, acc[RES_W-1:W]}
        + (acc[0] ? {1'b0, m} : '0);
    sh  = {acc[RES_W-1:W], acc[W-1]};
    df  = {1'b0, sh} - {2'b0, m};
    acc_n = acc;
    if (div_q) begin
      if (!df[W+1])
        acc_n = {df[W-1:0], acc[W-2:0], 1'b1};
      else
        acc_n = {sh[W-1:0], acc[W-2:0], 1'b0};
    end else begin
      acc_n = {sum, acc[W-1:1]};
    end
  end

  assign fin = run && (cnt == CW'(ITER - 1));

  assign prod_quot = div_q ?
    {{W{1'b0}}, acc_n[W-1:0]} : acc_n;
  assign rem = div_q ? acc_n[RES_W-1:W] : '0;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      run   <= 1'b0;
      div_q <= 1'b0;
      cnt   <= '0;
      m     <= '0;
      acc   <= '0;
    end else if (go) begin
      run   <= 1'b1;
      div_q <= is_div;
      cnt   <= '0;
      m     <= is_div ? b : a;
      acc   <= {{W{1'b0}}, is_div ? a : b};
    end else if (run) begin
      acc <= acc_n;
      cnt <= cnt + 1'b1;
      if (fin)
        run <= 1'b0;
    end
  end

endmodule

// File: rtl/rpn_executor.sv
// RPN evaluator: A op B from the entry stack, registered result + done.
// Optional status flags built only when RPN_FLAGS_EN is defined.
module rpn_executor
  import rpn_pkg::*;
#(
  parameter int ITER = W
) (
  input  logic Clk,
  input  logic Rst,
  rpn_executor_if.slave bus
);

  state_t state;
  state_t state_n;

  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [W-1:0]     op;
  logic             accept;
  logic             complete;
  logic             fin;
  logic [RES_W-1:0] mq;
  logic [W-1:0]     mr;
  logic [W:0]       sum;
  logic [W:0]       diff;
  logic [RES_W-1:0] res_n;
  logic [W-1:0]     rem_n;
  logic             err_n;
  logic [RES_W-1:0] res_q;
  logic [W-1:0]     rem_q;
  logic             err_q;
  logic             done_q;

  assign accept = (state == IDLE) && bus.start
               && (bus.Contador == STACK_FULL);

  rpn_seq_muldiv #(.ITER(ITER)) u_muldiv (
    .Clk       (Clk),
    .Rst       (Rst),
    .go        (accept),
    .is_div    (bus.T0 == OP_DIV),
    .a         (bus.T2),
    .b         (bus.T1),
    .fin       (fin),
    .prod_quot (mq),
    .rem       (mr)
  );

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    res_n    = '0;
    rem_n    = '0;
    err_n    = 1'b0;
    complete = 1'b1;
    unique case (1'b1)
      op == OP_ADD:
        res_n = {{(RES_W-W-1){1'b0}}, sum};
      op == OP_SUB:
        res_n = {{(RES_W-W-1){1'b0}}, diff};
      op == OP_MUL: begin
        res_n    = mq;
        complete = fin;
      end
      op == OP_DIV && b == '0: begin
        res_n = {{W{1'b0}}, {W{1'b1}}};
        rem_n = a;
        err_n = 1'b1;
      end
      op == OP_DIV && b != '0: begin
        res_n    = mq;
        rem_n    = mr;
        complete = fin;
      end
      op == OP_AND:
        res_n = {{W{1'b0}}, a & b};
      op == OP_OR:
        res_n = {{W{1'b0}}, a | b};
      op == OP_XOR:
        res_n = {{W{1'b0}}, a ^ b};
      default:
        err_n = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = EXEC;
      EXEC:    if (complete) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      a      <= '0;
      b      <= '0;
      op     <= '0;
      res_q  <= '0;
      rem_q  <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a     <= bus.T2;
        b     <= bus.T1;
        op    <= bus.T0;
        err_q <= 1'b0;
      end else if (state == EXEC && complete) begin
        res_q  <= res_n;
        rem_q  <= rem_n;
        err_q  <= err_n;
        done_q <= 1'b1;
      end
    end
  end

  assign bus.busy      = (state == EXEC);
  assign bus.done      = done_q;
  assign bus.erro      = err_q;
  assign bus.Resultado = res_q;
  assign bus.Resto     = rem_q;

`ifdef RPN_FLAGS_EN
  logic c_n;
  logic v_n;
  logic fz;
  logic fc;
  logic fv;

  // carry is bit W of the 9-bit sum/difference (borrow for SUB)
  always_comb begin
    c_n = 1'b0;
    v_n = 1'b0;
    if (op == OP_ADD) begin
      c_n = sum[W];
      v_n = (a[W-1] == b[W-1])
         && (sum[W-1] != a[W-1]);
    end else if (op == OP_SUB) begin
      c_n = diff[W];
      v_n = (a[W-1] != b[W-1])
         && (diff[W-1] != a[W-1]);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      fz <= 1'b0;
      fc <= 1'b0;
      fv <= 1'b0;
    end else if (accept) begin
      fz <= 1'b0;
      fc <= 1'b0;
      fv <= 1'b0;
    end else if (state == EXEC && complete) begin
      fz <= (res_n == '0);
      fc <= c_n;
      fv <= v_n;
    end
  end

  assign bus.flag_z = fz;
  assign bus.flag_c = fc;
  assign bus.flag_v = fv;
`else
  assign bus.flag_z = 1'b0;
  assign bus.flag_c = 1'b0;
  assign bus.flag_v = 1'b0;
`endif

endmodule
